// File: rtl/adding_machine_pkg.sv
// Shared types and widths for the adding-machine operand-entry path.
package adding_machine_pkg;

   localparam int OPERAND_W = 5;
   localparam int TOTAL_W   = 6;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer plus press/release debounce FSM.
// press_accept marks the edge on which a debounced press is taken.
module key_debounce
   import adding_machine_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press_accept,
   output logic busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic            sync_q;
   logic            key_s;
   logic [CW-1:0]   cnt;
   key_state_t      state;

   // Qualifying condition for the edge that leaves PRESS_WAIT; the parent
   // registers its effects on that same edge so there is no extra latency.
   assign press_accept = (state == PRESS_WAIT) && !key_s && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 1'b1;
         key_s  <= 1'b1;
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
      end else begin
         sync_q <= key_n;
         key_s  <= sync_q;
         case (state)
            IDLE: begin
               if (!key_s) begin
                  state <= PRESS_WAIT;
                  busy  <= 1'b1;
               end
            end
            PRESS_WAIT: begin
               if (key_s) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == LAST) begin
                  state <= HELD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (key_s) state <= RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               if (!key_s) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_accumulator.sv
// Adds/subtracts the switch operand into a 6-bit running total on each
// debounced key press; sticky ovf records any carry-out or borrow.
module key_accumulator
   import adding_machine_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET_N,
   input  logic                 KEY_N,
   input  logic [OPERAND_W-1:0] operand,
   input  logic                 sub,
   output logic [TOTAL_W-1:0]   total,
   output logic [OPERAND_W-1:0] last_operand,
   output logic                 ovf,
   output logic                 add_pulse,
   output logic                 busy
);

   logic             accept;
   logic [TOTAL_W:0] sum;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk          (CLOCK_50),
      .rst_n        (RESET_N),
      .key_n        (KEY_N),
      .press_accept (accept),
      .busy         (busy)
   );

   // Top bit of sum is the carry on add and the borrow on subtract.
   always_comb begin
      sum = '0;
      if (sub) sum = {1'b0, total} - {2'b0, operand};
      else     sum = {1'b0, total} + {2'b0, operand};
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         total        <= '0;
         last_operand <= '0;
         ovf          <= 1'b0;
         add_pulse    <= 1'b0;
      end else begin
         add_pulse <= accept;
         if (accept) begin
            total        <= sum[TOTAL_W-1:0];
            last_operand <= operand;
            if (sum[TOTAL_W]) ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_key_accumulator.sv
// Directed bench for key_accumulator with DEBOUNCE_CYCLES = 4.
module tb_key_accumulator;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N;
   logic       KEY_N;
   logic [4:0] operand;
   logic       sub;
   logic [5:0] total;
   logic [4:0] last_operand;
   logic       ovf;
   logic       add_pulse;
   logic       busy;

   int pass_cnt  = 0;
   int check_cnt = 0;

   key_accumulator #(.DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50     (CLOCK_50),
      .RESET_N      (RESET_N),
      .KEY_N        (KEY_N),
      .operand      (operand),
      .sub          (sub),
      .total        (total),
      .last_operand (last_operand),
      .ovf          (ovf),
      .add_pulse    (add_pulse),
      .busy         (busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Drives a clean press; edge 0 is the first edge that samples KEY_N low.
   task automatic do_press(input logic [4:0] op, input logic sb,
                           input logic [5:0] exp_total, input logic exp_ovf);
      int early = 0;
      operand = op;
      sub     = sb;
      KEY_N   = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         tick();
         if (e < 6 && add_pulse) early++;
         if (e == 1) begin
            check_cnt++;
            if (busy !== 1'b0) $display("FAIL busy_before_press_wait got %b want 0", busy);
            else pass_cnt++;
         end
         if (e == 2) begin
            check_cnt++;
            if (busy !== 1'b1) $display("FAIL busy_in_press_wait got %b want 1", busy);
            else pass_cnt++;
         end
      end
      check_cnt++;
      if (early != 0) $display("FAIL early_pulse got %0d pulses want 0", early);
      else pass_cnt++;
      check_cnt++;
      if (add_pulse !== 1'b1 || total !== exp_total || ovf !== exp_ovf || last_operand !== op)
         $display("FAIL accept_edge6 got pulse=%b total=%0d ovf=%b last=%0d want pulse=1 total=%0d ovf=%b last=%0d",
                  add_pulse, total, ovf, last_operand, exp_total, exp_ovf, op);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (add_pulse !== 1'b0 || total !== exp_total)
         $display("FAIL pulse_width got pulse=%b total=%0d want pulse=0 total=%0d", add_pulse, total, exp_total);
      else pass_cnt++;
   endtask

   // Clean release; busy must drop exactly 6 edges after the first high sample.
   task automatic do_release();
      KEY_N = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         tick();
         if (e == 5) begin
            check_cnt++;
            if (busy !== 1'b1) $display("FAIL busy_release_e5 got %b want 1", busy);
            else pass_cnt++;
         end
      end
      check_cnt++;
      if (busy !== 1'b0) $display("FAIL busy_release_e6 got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic apply_reset();
      RESET_N = 1'b0;
      KEY_N   = 1'b1;
      tick();
      tick();
      check_cnt++;
      if (total !== 6'd0 || last_operand !== 5'd0 || ovf !== 1'b0 || add_pulse !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_state got total=%0d last=%0d ovf=%b pulse=%b busy=%b want all 0",
                  total, last_operand, ovf, add_pulse, busy);
      else pass_cnt++;
      RESET_N = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_clean_press();
      do_press(5'd5, 1'b0, 6'd5, 1'b0);
      do_release();
   endtask

   task automatic test_bounce();
      int pulses = 0;
      int at_e   = -1;
      operand = 5'd2;
      sub     = 1'b0;
      for (int i = 0; i < 20; i++) begin
         KEY_N = ((i / 2) % 2) != 0;
         tick();
         if (add_pulse) pulses++;
      end
      KEY_N = 1'b0;
      for (int e = 0; e <= 7; e++) begin
         tick();
         if (add_pulse) begin
            pulses++;
            at_e = e;
         end
      end
      check_cnt++;
      if (pulses != 1 || at_e != 6)
         $display("FAIL bounce_accept got pulses=%0d at_edge=%0d want pulses=1 at_edge=6", pulses, at_e);
      else pass_cnt++;
      check_cnt++;
      if (total !== 6'd7) $display("FAIL bounce_total got %0d want 7", total);
      else pass_cnt++;
      do_release();
   endtask

   task automatic test_overflow();
      do_press(5'd31, 1'b0, 6'd38, 1'b0);
      do_release();
      do_press(5'd22, 1'b0, 6'd60, 1'b0);
      do_release();
      do_press(5'd7, 1'b0, 6'd3, 1'b1);
      do_release();
      do_press(5'd3, 1'b1, 6'd0, 1'b1);
      do_release();
   endtask

   task automatic test_underflow();
      apply_reset();
      do_press(5'd1, 1'b1, 6'd63, 1'b1);
      do_release();
   endtask

   task automatic test_hold_glitch();
      int pulses = 0;
      int drops  = 0;
      do_press(5'd4, 1'b0, 6'd3, 1'b1);
      for (int i = 0; i < 100; i++) begin
         KEY_N = (i >= 10) && ((i % 10 == 5) || (i % 10 == 6));
         tick();
         if (add_pulse) pulses++;
         if (!busy) drops++;
      end
      check_cnt++;
      if (pulses != 0) $display("FAIL hold_extra_accept got %0d want 0", pulses);
      else pass_cnt++;
      check_cnt++;
      if (drops != 0) $display("FAIL hold_busy_drop got %0d low cycles want 0", drops);
      else pass_cnt++;
      check_cnt++;
      if (total !== 6'd3) $display("FAIL hold_total got %0d want 3", total);
      else pass_cnt++;
      do_release();
   endtask

   task automatic test_reset_mid_press();
      int pulses = 0;
      int at_e   = -1;
      operand = 5'd9;
      sub     = 1'b0;
      KEY_N   = 1'b0;
      for (int e = 0; e <= 5; e++) begin
         tick();
         if (add_pulse) pulses++;
      end
      RESET_N = 1'b0;
      tick();
      check_cnt++;
      if (pulses != 0 || total !== 6'd0 || last_operand !== 5'd0 || ovf !== 1'b0 ||
          add_pulse !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_abort got pulses=%0d total=%0d last=%0d ovf=%b pulse=%b busy=%b want all 0",
                  pulses, total, last_operand, ovf, add_pulse, busy);
      else pass_cnt++;
      RESET_N = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         tick();
         if (add_pulse) begin
            pulses++;
            at_e = e;
         end
      end
      check_cnt++;
      if (pulses != 1 || at_e != 6)
         $display("FAIL held_through_reset got pulses=%0d at_edge=%0d want pulses=1 at_edge=6", pulses, at_e);
      else pass_cnt++;
      check_cnt++;
      if (total !== 6'd9 || ovf !== 1'b0 || last_operand !== 5'd9)
         $display("FAIL held_through_reset_val got total=%0d ovf=%b last=%0d want 9 0 9", total, ovf, last_operand);
      else pass_cnt++;
      do_release();
   endtask

   initial begin
      RESET_N = 1'b0;
      KEY_N   = 1'b1;
      operand = 5'd0;
      sub     = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_overflow();
      test_underflow();
      test_hold_glitch();
      test_reset_mid_press();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/key_accumulator.md
# key_accumulator

Sequential operand-entry stage that sits directly upstream of the two-digit seven-segment decoder in the adding-machine design. Each debounced press of an active-low push button adds or subtracts a 5-bit switch operand to or from a running 6-bit total. The registered total drives the decoder's 6-bit `b` input. Underflow or overflow is reported on a sticky flag for an LED.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a press or a release (10 ms at 50 MHz). Legal range is ≥1.
- `CLOCK_50`, input, 1: sole clock. All flops are on the rising edge.
- `RESET_N`, input, 1: reset, synchronous and active-low.
- `KEY_N`, input, 1: raw asynchronous push button. Low means pressed.
- `operand`, input, 5: switch value, normally `SW[4:0]`. Unsigned.
- `sub`, input, 1: selects the operation. 1 = subtract, 0 = add. Normally `SW[9]`.
- `total`, output, 6: running result. Feeds the decoder's `b` input.
- `last_operand`, output, 5: operand captured at the most recent accepted press.
- `ovf`, output, 1: sticky carry-out or borrow flag.
- `add_pulse`, output, 1: one-cycle strobe, high in the cycle `total` takes its new value.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- `KEY_N` passes through a 2-flop synchronizer; the result is `key_s`. Both synchronizer flops reset to 1 (released).
- FSM states and transitions:
  - IDLE → PRESS_WAIT when `key_s` = 0.
  - PRESS_WAIT: count consecutive `key_s` = 0 samples.
    - Any `key_s` = 1 returns to IDLE and clears the count.
    - When the count reaches DEBOUNCE_CYCLES: accept, then go to HELD.
  - HELD → RELEASE_WAIT when `key_s` = 1.
  - RELEASE_WAIT: count consecutive `key_s` = 1 samples.
    - Any `key_s` = 0 returns to HELD and clears the count.
    - When the count reaches DEBOUNCE_CYCLES: go to IDLE.
- Accept cycle: `operand` and `sub` are sampled once, on that edge only.
  - Add: `{c, total} <= {1'b0,total} + {2'b0,operand}`.
  - Subtract: `{c, total} <= {1'b0,total} - {2'b0,operand}`; `c` is the borrow.
  - `total` wraps modulo 64.
  - If `c` = 1, `ovf` is set. `ovf` clears only on reset.
  - `last_operand <= operand`.
  - `add_pulse` = 1 for exactly that cycle.
- Exactly one accept occurs per press, regardless of bounce or hold time.
- Reset values:
  - `total` = 0, `last_operand` = 0, `ovf` = 0, `add_pulse` = 0, `busy` = 0.
  - FSM in IDLE, counter = 0.
- Reset asserted mid-operation aborts on the next edge and enters the reset state; no partial accept.
- A key held through reset deassertion is debounced as a fresh press and is accepted.
- `operand` and `sub` are treated as quasi-static. They are not synchronized.

## Timing
- Let edge 0 be the first edge at which `KEY_N` is sampled low by the first synchronizer flop, with `KEY_N` stable low thereafter.
  - `key_s` = 0 is visible after edge 1.
  - PRESS_WAIT is entered at edge 2.
  - Accept occurs at edge 2 + DEBOUNCE_CYCLES.
  - The new `total` and `add_pulse` are visible from that edge.
- Total latency from press to `total` update is DEBOUNCE_CYCLES + 2 edges after edge 0.
- Release symmetry: IDLE is reached DEBOUNCE_CYCLES + 2 edges after the first high sample.
- The earliest next accept is DEBOUNCE_CYCLES + 2 edges after that.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `adding_machine_pkg`:
  - State enum `key_state_t` with values IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - Constants `OPERAND_W` = 5 and `TOTAL_W` = 6.
- Sub-module `key_debounce` contains the synchronizer, counter and FSM.
  - Outputs: `press_accept` (1-cycle) and `busy`.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `key_accumulator` contains the arithmetic and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then a clean press with `operand` = 5, `sub` = 0 → `total` = 5 and `add_pulse` high for 1 cycle, 6 edges after the first low sample; `ovf` = 0.
- Press bouncing low/high every 2 cycles for 20 cycles, then stable low → exactly one accept, timed from the final stable-low run.
- `total` = 60, add 7 → `total` = 3, `ovf` = 1. Then subtract 3 → `total` = 0 and `ovf` stays 1.
- From `total` = 0, subtract 1 → `total` = 63, `ovf` = 1.
- Key held 100 cycles with 2-cycle glitches high → single accept; `busy` stays 1 until 6 edges after the final release.
- `RESET_N` low during PRESS_WAIT with count = 3 → no accept, all outputs 0 next edge. With the key still held after reset, one accept occurs 6 edges after reset release.
